pc_ras_unit: RTL
================

# pc_ras_unit

Parametrised program counter with sequential increment, absolute load, PC-relative branch, stall, and a hardware return-address stack (RAS) for call/return. It is the next-generation fetch-address generator for the 16-bit core: it drives the instruction-memory address and takes control directives from the decode/branch logic. All state is registered on one clock, with a synchronous active-low reset.

## Interface
- WIDTH, 16: PC and address width in bits (≥4).
- STEP, 1: increment applied on a sequential advance, in address units (1..2^WIDTH-1).
- RESET_VECTOR, 0: PC value after reset.
- RAS_DEPTH, 4: number of return-address entries (≥2).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous and active-low (0 = reset).
- en  in  1  advance enable; 0 = stall, all state held.
- load  in  1  absolute jump to pc_in.
- pc_in  in  WIDTH  jump/call target.
- branch  in  1  relative branch, pc_out + offset.
- offset  in  WIDTH  two's-complement branch offset.
- call  in  1  push return address, jump to pc_in.
- ret  in  1  pop return address into PC.
- pc_out  out  WIDTH  current PC (registered).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_overflow  out  1  one-cycle pulse: a call dropped the oldest entry.
- ras_underflow  out  1  one-cycle pulse: ret issued with the RAS empty.

## Operation
- Reset (reset=0 at an edge): pc_out=RESET_VECTOR, RAS count=0, ras_empty=1, ras_full=0, both error pulses 0. Stack contents are don't-care.
- When en=1, a single operation is selected per cycle by fixed priority: ret > call > load > branch > increment. Lower-priority requests in the same cycle are ignored.
- When en=0, pc_out, the RAS and the count all hold, and both error pulses are 0 that cycle. The stall overrides every control input but never overrides reset.
- Increment: pc_out ← pc_out + STEP.
- Load: pc_out ← pc_in.
- Branch: pc_out ← pc_out + offset.
- Call: push (pc_out + STEP), then pc_out ← pc_in.
  - If count < RAS_DEPTH: count+1.
  - If count = RAS_DEPTH: the oldest entry is discarded, the new one becomes top, count stays RAS_DEPTH, and ras_overflow pulses. Implement the RAS as a circular buffer indexed by a top pointer.
- Ret with count > 0: pc_out ← top entry, count-1.
- Ret with count = 0: behaves as increment, and ras_underflow pulses.
- Arithmetic: all adds are modulo 2^WIDTH. Wrap-around is silent, with no flag. The offset is interpreted as signed WIDTH-bit.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are decoded from the registered count.

## Timing
- pc_out is registered. An operation sampled at edge N is visible on pc_out immediately after edge N, with zero additional latency.
- Controls are sampled only at the rising edge. There is no combinational path from any input to any output.
- ras_overflow and ras_underflow are registered and high for exactly the one cycle following the offending edge.
- ras_empty and ras_full reflect the count after the same edge that updated pc_out.
- Back-to-back call/ret on consecutive cycles is fully supported. A ret immediately after a call returns the just-pushed address.
- Reset mid-operation: reset at an edge wins over every input including en=0. Any pending push or pop is lost and the RAS is empty after that edge.
- Release: the first edge with reset=1 performs the operation selected by the inputs, starting from RESET_VECTOR.

## Test plan
- Reset and increment (WIDTH=16, STEP=1, RESET_VECTOR=0): reset=0 for 1 edge, then en=1 idle for 3 edges -> pc_out 0000, 0001, 0002, 0003; ras_empty=1.
- Load, branch and wrap:
  - pc_out=0050, load with pc_in=00A0 -> 00A0.
  - Branch with offset=FFF0 -> 0090.
  - From FFFF, increment -> 0000, with no flag.
- Stall and priority:
  - en=0 with load=1 for 2 edges -> pc_out unchanged.
  - load+branch+call together, pc_out=0010, pc_in=0200 -> pc_out 0200 and top entry 0011 (call wins).
- Nested call/return (RAS_DEPTH=4):
  - From 0010, call 0100, then call 0200 -> count=2.
  - ret -> 0101, then ret -> 0011; ras_empty=1.
- RAS overflow and underflow:
  - 5 consecutive calls from 0000 targeting 0100, 0200, 0300, 0400, 0500 -> ras_overflow high exactly after the 5th edge; ras_full=1.
  - 4 rets -> 0401, 0301, 0201, 0101.
  - 5th ret -> pc_out 0102 and ras_underflow pulses once.
- Reset mid-operation: after 2 calls, assert reset=0 together with ret=1 -> pc_out=RESET_VECTOR, ras_empty=1, no error pulse.

Source files
------------

// File: rtl/pc_ras_unit.sv
// Fetch-address generator: program counter with increment, load, relative branch,
// stall, and a circular return-address stack for call/return.
module pc_ras_unit #(
   parameter int WIDTH        = 16,
   parameter int STEP         = 1,
   parameter int RESET_VECTOR = 0,
   parameter int RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             branch,
   input  logic [WIDTH-1:0] offset,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] pc_out,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow,
   output logic             ras_underflow
);

   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);

   localparam logic [WIDTH-1:0] STEP_C     = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_C    = WIDTH'(RESET_VECTOR);
   localparam logic [PW-1:0]    IDX_ZERO   = PW'(0);
   localparam logic [PW-1:0]    IDX_ONE    = PW'(1);
   localparam logic [PW-1:0]    IDX_LAST   = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0]    CNT_ZERO   = CW'(0);
   localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
   localparam logic [CW-1:0]    CNT_DEPTH  = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
   logic [PW-1:0]    top_r;
   logic [CW-1:0]    count_r;
   logic             ovf_r;
   logic             unf_r;

   logic [WIDTH-1:0] pc_nxt_s;
   logic [WIDTH-1:0] seq_pc_s;
   logic [PW-1:0]    top_nxt_s;
   logic [PW-1:0]    top_inc_s;
   logic [PW-1:0]    top_dec_s;
   logic [CW-1:0]    count_nxt_s;
   logic             push_s;
   logic             ovf_nxt_s;
   logic             unf_nxt_s;

   // Next-state selection; priority is ret > call > load > branch > increment.
   always_comb begin
      pc_nxt_s    = pc_r;
      top_nxt_s   = top_r;
      count_nxt_s = count_r;
      push_s      = 1'b0;
      ovf_nxt_s   = 1'b0;
      unf_nxt_s   = 1'b0;
      seq_pc_s    = pc_r + STEP_C;
      top_inc_s   = (top_r == IDX_LAST) ? IDX_ZERO : top_r + IDX_ONE;
      top_dec_s   = (top_r == IDX_ZERO) ? IDX_LAST : top_r - IDX_ONE;
      if (en) begin
         if (ret) begin
            if (count_r != CNT_ZERO) begin
               pc_nxt_s    = ras_mem_r[top_r];
               top_nxt_s   = top_dec_s;
               count_nxt_s = count_r - CNT_ONE;
            end else begin
               pc_nxt_s  = seq_pc_s;
               unf_nxt_s = 1'b1;
            end
         end else if (call) begin
            // A full stack wraps the top pointer onto the oldest slot, overwriting it.
            push_s    = 1'b1;
            pc_nxt_s  = pc_in;
            top_nxt_s = top_inc_s;
            if (count_r == CNT_DEPTH) begin
               ovf_nxt_s = 1'b1;
            end else begin
               count_nxt_s = count_r + CNT_ONE;
            end
         end else if (load) begin
            pc_nxt_s = pc_in;
         end else if (branch) begin
            pc_nxt_s = pc_r + offset;
         end else begin
            pc_nxt_s = seq_pc_s;
         end
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // PC, stack pointer, occupancy and error-pulse registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_r    <= RESET_C;
         top_r   <= IDX_ZERO;
         count_r <= CNT_ZERO;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         pc_r    <= pc_nxt_s;
         top_r   <= top_nxt_s;
         count_r <= count_nxt_s;
         ovf_r   <= ovf_nxt_s;
         unf_r   <= unf_nxt_s;
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (reset && push_s) begin
         ras_mem_r[top_nxt_s] <= seq_pc_s;
      end
   end

   assign pc_out        = pc_r;
   assign ras_empty     = (count_r == CNT_ZERO);
   assign ras_full      = (count_r == CNT_DEPTH);
   assign ras_overflow  = ovf_r;
   assign ras_underflow = unf_r;

endmodule
